vector_dac_sequencer: RTL and testbench
=======================================

Name: vector_dac_sequencer

Overview:
- Sits between the Bresenham line generator and the dual-channel SPI DAC driver.
- Watches the generator's current X/Y point. When the point changes, it holds the generator and writes the changed axes to the DAC, one at a time, X first.
- It then pulses LDAC so both DAC outputs update together, waits a settle time, and releases the generator.
- The beam-enable (Z) output is updated on the same LDAC pulse, so intensity stays aligned with position.

Parameters:
- BITS, 12, coordinate width; must match the DAC value width.
- LDAC_CYCLES, 2, number of clk cycles ldac_n is held low (1..15).
- SETTLE_CYCLES, 4, idle clk cycles after LDAC before halt is released (0..255).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- x_in  input  BITS  current X point from the line generator.
- y_in  input  BITS  current Y point from the line generator.
- z_in  input  1  beam enable that accompanies the current point.
- force  input  1  one-cycle request to rewrite both axes even if unchanged.
- halt  output  1  stalls the line generator; combinational.
- dac_value  output  BITS  value presented to the DAC driver.
- dac_axis  output  1  0 = X channel, 1 = Y channel.
- dac_strobe  output  1  one-cycle start pulse to the DAC driver.
- dac_ready  input  1  high when the DAC driver is idle.
- ldac_n  output  1  active-low latch pulse to the DAC.
- z_out  output  1  registered beam enable.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset is asynchronous and active-low.
- Asynchronous reset values: state=IDLE, last_x=0, last_y=0, init_pend=1, dac_strobe=0, dac_value=0, dac_axis=0, ldac_n=1, z_out=0, counters=0.
- Combinational signals:
  - chg_x = (x_in != last_x) | init_pend | force.
  - chg_y = (y_in != last_y) | init_pend | force.
  - halt = !reset_n | (state != IDLE) | chg_x | chg_y. Because halt is combinational, the generator never advances in the same cycle a new point appears.
- IDLE:
  - If chg_x: latch lat_x=x_in, lat_y=y_in, lat_z=z_in, and record wy=chg_y; go to WR_X.
  - Else if chg_y: latch lat_x, lat_y and lat_z the same way; go to WR_Y.
  - Else stay in IDLE.
- WR_X:
  - Wait while dac_ready=0.
  - When dac_ready=1: drive dac_strobe=1 for exactly one cycle, dac_axis=0, dac_value=lat_x; go to WAIT_X.
- WAIT_X:
  - Wait until dac_ready has been seen low and then high again. dac_ready low is tolerated starting the cycle after the strobe.
  - Then last_x<=lat_x, and go to WR_Y if wy=1, else to LDAC.
- WR_Y / WAIT_Y: identical to WR_X / WAIT_X with dac_axis=1 and dac_value=lat_y; on completion last_y<=lat_y, then go to LDAC.
- LDAC:
  - ldac_n=0 for LDAC_CYCLES cycles.
  - z_out<=lat_z on the first LDAC cycle.
  - On exit ldac_n=1, init_pend<=0, then go to SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES, then go to IDLE.
  - SETTLE_CYCLES=0 goes straight to IDLE.
- force:
  - Sampled only in IDLE.
  - A force pulse arriving in any other state is dropped, not queued.
- Outputs: dac_value and dac_axis hold their last values between strobes.
- Inputs changing mid-transaction: x_in/y_in/z_in changes are ignored until IDLE, then detected by the compare logic.
- Reset mid-transaction: all state is cleared immediately. ldac_n goes high at once. A DAC frame already in flight is abandoned. init_pend=1, so the first IDLE cycle after reset forces a write of both axes.
- Minimum latency, single-axis change, dac_ready always high:
  - IDLE detect → strobe on cycle 1.
  - The DAC driver's busy time follows.
  - Then LDAC_CYCLES, then SETTLE_CYCLES.
- Width rules: no arithmetic on coordinates. Counters are sized to hold LDAC_CYCLES and SETTLE_CYCLES.

Test Plan:
1. Reset release with x_in=0x123, y_in=0x456, z_in=1, DAC model with a 33-cycle busy time:
   - exactly two strobes: axis0/0x123, then axis1/0x456;
   - then one ldac_n low pulse of 2 cycles, with z_out=1 from that pulse;
   - halt is held high throughout and drops 4 cycles after ldac_n rises.
2. Idle at (0x100,0x200), step x_in to 0x101:
   - halt rises in the same cycle;
   - one strobe only, axis0/0x101;
   - no Y write; one LDAC pulse.
3. Idle, step only y_in from 0x200 to 0x1FF:
   - one strobe only, axis1/0x1FF;
   - last_x is unchanged;
   - a following step of x_in triggers an X-only write.
4. Change x_in and y_in again during WAIT_X of a transaction:
   - the in-flight transaction completes with the latched values;
   - on return to IDLE a new transaction starts with the new values.
5. force pulse in IDLE with an unchanged point: both axes are rewritten and one LDAC pulse is issued. force pulse during WAIT_Y: no extra transaction.
6. Assert reset_n=0 during LDAC: ldac_n goes high and halt=1 asynchronously. After release, a full two-axis write of the current inputs occurs.

Source files
------------

// File: rtl/vector_dac_sequencer_if.sv
// vector_dac_sequencer_if: link between the vector sequencer and the dual-channel SPI DAC driver.
// Signals:
//   dac_value  - coordinate presented to the DAC driver
//   dac_axis   - 0 selects the X channel, 1 selects the Y channel
//   dac_strobe - one-cycle start pulse for a DAC frame
//   dac_ready  - driver idle indication
//   ldac_n     - active-low latch pulse that updates both DAC outputs together
// Modports: master is the sequencer, slave is the DAC driver.
interface vector_dac_sequencer_if #(
    parameter int BITS = 12
);
    logic [BITS-1:0] dac_value;
    logic            dac_axis;
    logic            dac_strobe;
    logic            dac_ready;
    logic            ldac_n;
    modport master (output dac_value, dac_axis, dac_strobe, ldac_n, input dac_ready);
    modport slave  (input dac_value, dac_axis, dac_strobe, ldac_n, output dac_ready);
endinterface

// File: rtl/vector_dac_sequencer.sv
// vector_dac_sequencer: holds the line generator while changed axes are written to the DAC, then latches them with LDAC.
// Ports:
//   clk, reset_n      - clock and asynchronous active-low reset
//   x_in, y_in, z_in  - current point and beam enable from the line generator
//   force_in          - one-cycle request to rewrite both axes (sampled in IDLE only)
//   halt              - combinational stall to the line generator
//   z_out             - beam enable, updated together with the LDAC pulse
//   busy              - high whenever the sequencer is not idle
//   dac               - DAC driver bus (value, axis, strobe, ready, ldac_n)
module vector_dac_sequencer #(
    parameter int BITS          = 12,
    parameter int LDAC_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BITS-1:0]       x_in,
    input  logic [BITS-1:0]       y_in,
    input  logic                  z_in,
    input  logic                  force_in,
    output logic                  halt,
    output logic                  z_out,
    output logic                  busy,
    vector_dac_sequencer_if.master dac
);
    typedef enum logic [2:0] {IDLE, WR_X, WAIT_X, WR_Y, WAIT_Y, LDAC, SETTLE} state_t;

    state_t          state, state_d;
    logic [BITS-1:0] last_x, last_y, lat_x, lat_y;
    logic            lat_z, wy, init_pend, seen_low;
    logic [7:0]      cnt;
    logic            chg_x, chg_y, done, waiting;

    assign chg_x   = (x_in != last_x) | init_pend | force_in;
    assign chg_y   = (y_in != last_y) | init_pend | force_in;
    assign halt    = !reset_n | (state != IDLE) | chg_x | chg_y;
    assign busy    = state != IDLE;
    assign waiting = (state == WAIT_X) | (state == WAIT_Y);
    // A frame is complete only once the driver has gone busy and come back.
    assign done    = seen_low & dac.dac_ready;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = chg_x ? WR_X : chg_y ? WR_Y : IDLE;
            WR_X:    state_d = dac.dac_ready ? WAIT_X : WR_X;
            WAIT_X:  state_d = !done ? WAIT_X : wy ? WR_Y : LDAC;
            WR_Y:    state_d = dac.dac_ready ? WAIT_Y : WR_Y;
            WAIT_Y:  state_d = done ? LDAC : WAIT_Y;
            LDAC:    state_d = cnt != 8'(LDAC_CYCLES - 1) ? LDAC : SETTLE_CYCLES == 0 ? IDLE : SETTLE;
            SETTLE:  state_d = cnt == 8'(SETTLE_CYCLES - 1) ? IDLE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_x         <= '0;
            last_y         <= '0;
            lat_x          <= '0;
            lat_y          <= '0;
            lat_z          <= 1'b0;
            wy             <= 1'b0;
            init_pend      <= 1'b1;
            seen_low       <= 1'b0;
            cnt            <= '0;
            dac.dac_strobe <= 1'b0;
            dac.dac_value  <= '0;
            dac.dac_axis   <= 1'b0;
            dac.ldac_n     <= 1'b1;
            z_out          <= 1'b0;
        end else begin
            dac.dac_strobe <= 1'b0;
            dac.ldac_n     <= state_d != LDAC;
            cnt            <= (state_d != state) ? '0 : cnt + 8'd1;
            seen_low       <= waiting & (state_d == state) & (seen_low | !dac.dac_ready);
            if (state == IDLE && (chg_x || chg_y)) begin
                lat_x <= x_in;
                lat_y <= y_in;
                lat_z <= z_in;
                wy    <= chg_y;
            end
            if ((state == WR_X || state == WR_Y) && dac.dac_ready) begin
                dac.dac_strobe <= 1'b1;
                dac.dac_axis   <= state == WR_Y;
                dac.dac_value  <= state == WR_Y ? lat_y : lat_x;
            end
            if (state == WAIT_X && done) last_x <= lat_x;
            if (state == WAIT_Y && done) last_y <= lat_y;
            // Beam enable changes on the same edge that starts the LDAC pulse.
            if (state_d == LDAC && state != LDAC) z_out <= lat_z;
            if (state == LDAC && state_d != LDAC) init_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vector_dac_sequencer.sv
// tb_vector_dac_sequencer: directed checks of the vector DAC sequencer against a 33-cycle DAC driver model.
module tb_vector_dac_sequencer;
    localparam int BUSY = 33;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] x_in = '0, y_in = '0;
    logic        z_in = 1'b0, force_in = 1'b0;
    logic        halt, z_out, busy;
    int          errors = 0, checks = 0;

    vector_dac_sequencer_if #(.BITS(12)) dac_if ();

    vector_dac_sequencer #(.BITS(12), .LDAC_CYCLES(2), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .force_in(force_in), .halt(halt), .z_out(z_out), .busy(busy), .dac(dac_if)
    );

    always #5 clk = ~clk;

    // DAC driver model: goes busy the cycle after it samples a strobe.
    int busy_cnt = 0;
    initial dac_if.dac_ready = 1'b1;
    always @(posedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) dac_if.dac_ready <= 1'b1;
        end else if (dac_if.dac_strobe) begin
            busy_cnt <= BUSY;
            dac_if.dac_ready <= 1'b0;
        end
    end

    // Monitor: logs strobes, LDAC pulses and the halt time after each LDAC pulse.
    logic [11:0] s_val[$];
    logic        s_axis[$];
    int          n_ldac = 0, last_len = 0, low_run = 0, settle_cnt = 0, settle_len = -1;
    bit          counting = 0;
    logic        z_at_ldac = 1'b0;
    always @(negedge clk) begin
        if (dac_if.dac_strobe) begin
            s_val.push_back(dac_if.dac_value);
            s_axis.push_back(dac_if.dac_axis);
        end
        if (counting) begin
            if (halt) settle_cnt++;
            else begin
                counting = 0;
                settle_len = settle_cnt;
            end
        end
        if (!dac_if.ldac_n) begin
            low_run++;
            if (low_run == 1) z_at_ldac = z_out;
        end else if (low_run != 0) begin
            n_ldac++;
            last_len = low_run;
            low_run = 0;
            counting = 1;
            settle_cnt = halt ? 1 : 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] strobe_at(input int i);
        return i < s_val.size() ? {19'd0, s_axis[i], s_val[i]} : 32'hDEAD;
    endfunction

    task automatic clear_log();
        s_val.delete();
        s_axis.delete();
        n_ldac = 0;
        low_run = 0;
        counting = 0;
        settle_len = -1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            if (!busy && !halt) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_strobe(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (dac_if.dac_strobe) return;
        end
        check({tag, "_strobe_timeout"}, 0, 1);
    endtask

    initial begin
        int lows;
        // 1: reset state, then the forced initial two-axis write
        x_in = 12'h123; y_in = 12'h456; z_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_halt", halt, 1);
        check("rst_ldac", dac_if.ldac_n, 1);
        check("rst_strobe", dac_if.dac_strobe, 0);
        check("rst_value", dac_if.dac_value, 0);
        check("rst_z", z_out, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        clear_log();
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 300 && n_ldac == 0; i++) begin
            @(negedge clk);
            #1;
            if (!halt) lows++;
        end
        check("t1_halt_held", lows, 0);
        wait_idle("t1", 100);
        check("t1_nstr", s_val.size(), 2);
        check("t1_str0", strobe_at(0), {20'd0, 12'h123});
        check("t1_str1", strobe_at(1), {20'd1, 12'h456});
        check("t1_nldac", n_ldac, 1);
        check("t1_ldac_len", last_len, 2);
        check("t1_z_at_ldac", z_at_ldac, 1);
        check("t1_settle", settle_len, 4);

        // 2: X-only step, halt rises combinationally
        x_in = 12'h100; y_in = 12'h200;
        wait_idle("t2_setup", 300);
        clear_log();
        x_in = 12'h101; z_in = 1'b0;
        #1;
        check("t2_halt_same", halt, 1);
        check("t2_busy_same", busy, 0);
        wait_idle("t2", 300);
        check("t2_nstr", s_val.size(), 1);
        check("t2_str0", strobe_at(0), {20'd0, 12'h101});
        check("t2_nldac", n_ldac, 1);
        check("t2_z", z_out, 0);

        // 3: Y-only step, then X-only step
        clear_log();
        y_in = 12'h1FF;
        wait_idle("t3", 300);
        check("t3_nstr", s_val.size(), 1);
        check("t3_str0", strobe_at(0), {20'd1, 12'h1FF});
        check("t3_nldac", n_ldac, 1);
        clear_log();
        x_in = 12'h102;
        wait_idle("t3b", 300);
        check("t3b_nstr", s_val.size(), 1);
        check("t3b_str0", strobe_at(0), {20'd0, 12'h102});

        // 4: inputs change during WAIT_X
        clear_log();
        x_in = 12'h300; z_in = 1'b1;
        wait_strobe("t4");
        repeat (3) @(negedge clk);
        x_in = 12'h310; y_in = 12'h320;
        wait_idle("t4", 600);
        check("t4_nstr", s_val.size(), 3);
        check("t4_str0", strobe_at(0), {20'd0, 12'h300});
        check("t4_str1", strobe_at(1), {20'd0, 12'h310});
        check("t4_str2", strobe_at(2), {20'd1, 12'h320});
        check("t4_nldac", n_ldac, 2);
        check("t4_z", z_out, 1);

        // 5: force in IDLE rewrites both axes; force during WAIT_Y is dropped
        clear_log();
        force_in = 1'b1;
        @(negedge clk);
        force_in = 1'b0;
        wait_idle("t5", 300);
        check("t5_nstr", s_val.size(), 2);
        check("t5_str0", strobe_at(0), {20'd0, 12'h310});
        check("t5_str1", strobe_at(1), {20'd1, 12'h320});
        check("t5_nldac", n_ldac, 1);
        clear_log();
        y_in = 12'h321;
        wait_strobe("t5b");
        repeat (5) @(negedge clk);
        force_in = 1'b1;
        @(negedge clk);
        force_in = 1'b0;
        wait_idle("t5b", 300);
        check("t5b_nstr", s_val.size(), 1);
        check("t5b_str0", strobe_at(0), {20'd1, 12'h321});
        check("t5b_nldac", n_ldac, 1);

        // 6: reset during LDAC
        x_in = 12'h400;
        for (int i = 0; i < 300 && dac_if.ldac_n; i++) begin
            @(negedge clk);
            #1;
        end
        check("t6_in_ldac", dac_if.ldac_n, 0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_ldac_async", dac_if.ldac_n, 1);
        check("t6_halt_async", halt, 1);
        check("t6_busy_async", busy, 0);
        check("t6_z_async", z_out, 0);
        repeat (2) @(negedge clk);
        clear_log();
        reset_n = 1'b1;
        wait_idle("t6", 300);
        check("t6_nstr", s_val.size(), 2);
        check("t6_str0", strobe_at(0), {20'd0, 12'h400});
        check("t6_str1", strobe_at(1), {20'd1, 12'h321});
        check("t6_nldac", n_ldac, 1);
        check("t6_z", z_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
